// File: rtl/sram_wr_pkg.sv
// Shared sizing constants, FSM state type and length clamp for the scratch-SRAM write sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_wr_pkg;

    // Default array geometry: 64 banks x 128 words
    localparam int NUM_BANK   = 64;
    localparam int ADDR_W     = 7;

    // One full pass covers every word of every bank
    localparam int SRAM_WORDS = 8192;

    // Width of the length/count fields (holds 0..8192)
    localparam int CNT_W      = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } wr_state_t;

    // Requests longer than the array saturate to a full pass
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] l);
        return (l > CNT_W'(SRAM_WORDS)) ? CNT_W'(SRAM_WORDS) : l;
    endfunction

endpackage

// File: rtl/sram_wr_addr_cnt.sv
// Bank/address/word counters walking the array bank-major: banks 0..N-1 at one address, then next address.
// Latency: counters update on the edge after clear/advance; last is combinational from the count.
// Backpressure: none; the owner only advances on an accepted word.
module sram_wr_addr_cnt #(
    parameter int NUM_BANK = sram_wr_pkg::NUM_BANK,
    parameter int ADDR_W   = sram_wr_pkg::ADDR_W,
    parameter int BANK_W   = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_i,
    input  logic                          advance_i,
    input  logic [sram_wr_pkg::CNT_W-1:0] len_i,
    output logic [BANK_W-1:0]             bank_o,
    output logic [ADDR_W-1:0]             addr_o,
    output logic                          last_o
);
    import sram_wr_pkg::*;

    logic [BANK_W-1:0] bank_q,  bank_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Next-state: clear wins; otherwise step bank, and step address when the last bank is passed
    always_comb begin
        bank_d  = bank_q;
        addr_d  = addr_q;
        count_d = count_q;
        if (clear_i) begin
            bank_d  = '0;
            addr_d  = '0;
            count_d = '0;
        end else if (advance_i) begin
            count_d = count_q + 1'b1;
            if (bank_q == BANK_W'(NUM_BANK - 1)) begin
                bank_d = '0;
                // Address wraps to 0 only after the final word of a full pass
                addr_d = addr_q + 1'b1;
            end else begin
                bank_d = bank_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q  <= '0;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign bank_o = bank_q;
    assign addr_o = addr_q;
    // The word being offered now is the final one of the pass
    assign last_o = (count_q == (len_i - CNT_W'(1)));

endmodule

// File: rtl/sram_write_ctrl.sv
// Write-side sequencer: spreads a valid/ready word stream round-robin over the scratch-SRAM banks; SRAM_WR_ABORT_EN adds an abort input.
// Latency: start->in_ready 1 cycle; accept->bank write strobe 1 cycle; last accept->done 1 cycle (with final strobe).
// Backpressure: in_ready is high only in FILL; held-off words are simply not accepted and no strobe issues.
module sram_write_ctrl #(
    parameter int NUM_BANK = sram_wr_pkg::NUM_BANK,
    parameter int ADDR_W   = sram_wr_pkg::ADDR_W,
    parameter int DATA_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [sram_wr_pkg::CNT_W-1:0] len,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
`ifdef SRAM_WR_ABORT_EN
    input  logic                          abort,
`endif
    output logic                          in_ready,
    output logic                          input_rw_select      [0:NUM_BANK-1],
    output logic [ADDR_W-1:0]             input_SRAM_A_write   [0:NUM_BANK-1],
    output logic                          input_SRAM_CEN_write [0:NUM_BANK-1],
    output logic                          SRAM_WEN             [0:NUM_BANK-1],
    output logic [DATA_W-1:0]             SRAM_D,
    output logic                          busy,
    output logic                          done
);
    import sram_wr_pkg::*;

    localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

    wr_state_t         state_q, state_d;
    logic [CNT_W-1:0]  len_q,   len_d;

    logic              accept;
    logic              cnt_clear;
    logic [BANK_W-1:0] cur_bank;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_last;
    logic              abort_req;

    // Registered per-bank write-issue stage
    logic              rw_sel_q [0:NUM_BANK-1];
    logic              cen_q    [0:NUM_BANK-1];
    logic              wen_q    [0:NUM_BANK-1];
    logic [ADDR_W-1:0] a_q      [0:NUM_BANK-1];
    logic [DATA_W-1:0] d_q;
    logic              wr_hit_d [0:NUM_BANK-1];

`ifdef SRAM_WR_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign accept = in_valid & in_ready;

    sram_wr_addr_cnt #(
        .NUM_BANK (NUM_BANK),
        .ADDR_W   (ADDR_W),
        .BANK_W   (BANK_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (cnt_clear),
        .advance_i (accept),
        .len_i     (len_q),
        .bank_o    (cur_bank),
        .addr_o    (cur_addr),
        .last_o    (cur_last)
    );

    // FSM next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cnt_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = clamp_len(len);
                    cnt_clear = 1'b1;
                    state_d   = (clamp_len(len) == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // Abort beats a final accept so done is never pulsed on abort
                if (abort_req) begin
                    state_d = IDLE;
                end else if (accept && cur_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and latched pass length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    // Decode which single bank the accepted word targets
    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            wr_hit_d[b] = accept && (cur_bank == BANK_W'(b));
        end
    end

    // Issue stage: strobe only the hit bank; idle banks stay on the read path, addresses and data hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                rw_sel_q[b] <= 1'b0;
                cen_q[b]    <= 1'b1;
                wen_q[b]    <= 1'b1;
                a_q[b]      <= '0;
            end
            d_q <= '0;
        end else begin
            for (int b = 0; b < NUM_BANK; b++) begin
                rw_sel_q[b] <= wr_hit_d[b];
                cen_q[b]    <= ~wr_hit_d[b];
                wen_q[b]    <= ~wr_hit_d[b];
                if (wr_hit_d[b]) begin
                    a_q[b] <= cur_addr;
                end
            end
            if (accept) begin
                d_q <= in_data;
            end
        end
    end

    assign input_rw_select      = rw_sel_q;
    assign input_SRAM_CEN_write = cen_q;
    assign SRAM_WEN             = wen_q;
    assign input_SRAM_A_write   = a_q;
    assign SRAM_D               = d_q;

endmodule

// File: tb/tb_sram_write_ctrl.sv
// Directed bench for sram_write_ctrl: cycle table plus stream, reset and abort sequences.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Every wait on the design is bounded by a cycle budget.
module tb_sram_write_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        rw_sel [0:63];
    logic [6:0]  a_wr   [0:63];
    logic        cen    [0:63];
    logic        wen    [0:63];
    logic [31:0] sram_d;
    logic        busy;
    logic        done;
`ifdef SRAM_WR_ABORT_EN
    logic        abort;
`endif

    int checks   = 0;
    int failures = 0;

    sram_write_ctrl #(
        .NUM_BANK (64),
        .ADDR_W   (7),
        .DATA_W   (32)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .len                  (len),
        .in_valid             (in_valid),
        .in_data              (in_data),
`ifdef SRAM_WR_ABORT_EN
        .abort                (abort),
`endif
        .in_ready             (in_ready),
        .input_rw_select      (rw_sel),
        .input_SRAM_A_write   (a_wr),
        .input_SRAM_CEN_write (cen),
        .SRAM_WEN             (wen),
        .SRAM_D               (sram_d),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [13:0] len;
        logic        vld;
        logic [31:0] dat;
        logic        e_rdy;
        logic        e_busy;
        logic        e_done;
        int          e_bank;   // -1: no strobe expected
        int          e_addr;
        logic [31:0] e_dat;
    } vec_t;

    vec_t vt [17];

    // stream results
    int s_cnt, s_bad, s_done, s_done_last, s_lb, s_la;
    int s_w63_b, s_w63_a, s_w64_b, s_w64_a;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns strobed bank, -1 for none, -2 for inconsistent per-bank controls or multiple banks
    function automatic int scan();
        int hit = -1;
        int n   = 0;
        bit bad = 1'b0;
        for (int b = 0; b < 64; b++) begin
            if (rw_sel[b] === 1'b1) begin
                n++;
                hit = b;
                if (cen[b] !== 1'b0 || wen[b] !== 1'b0) bad = 1'b1;
            end else if (rw_sel[b] !== 1'b0 || cen[b] !== 1'b1 || wen[b] !== 1'b1) begin
                bad = 1'b1;
            end
        end
        if (bad || n > 1) return -2;
        return hit;
    endfunction

    function automatic int addr_sum();
        int s = 0;
        for (int b = 0; b < 64; b++) s += int'(a_wr[b]);
        return s;
    endfunction

    // Start a pass of L words and feed back-to-back words base+k until done or budget runs out
    task automatic run_stream(input int L, input logic [31:0] base, input int budget);
        int   sent;
        int   cyc;
        int   s;
        logic acc;
        s_cnt = 0; s_bad = 0; s_done = 0; s_done_last = 0; s_lb = -1; s_la = -1;
        s_w63_b = -1; s_w63_a = -1; s_w64_b = -1; s_w64_a = -1;
        @(negedge clk);
        start = 1'b1; len = L[13:0]; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; sent = 0; cyc = 0;
        while (s_done == 0 && cyc < budget) begin
            in_data = base + sent;
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            s = scan();
            if (s == -2) begin
                s_bad++;
            end else if (s >= 0) begin
                if (s != s_cnt % 64 || int'(a_wr[s]) != (s_cnt / 64) % 128 || sram_d != base + s_cnt)
                    s_bad++;
                if (s_cnt == 63) begin s_w63_b = s; s_w63_a = int'(a_wr[s]); end
                if (s_cnt == 64) begin s_w64_b = s; s_w64_a = int'(a_wr[s]); end
                s_lb = s;
                s_la = int'(a_wr[s]);
                s_cnt++;
            end
            if (done) begin
                s_done = 1;
                s_done_last = (s >= 0) ? 1 : 0;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        int d;
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
`ifdef SRAM_WR_ABORT_EN
        abort = 1'b0;
`endif
        //            start len    vld dat       rdy  busy done  bank addr edat
        vt[0]  = '{1'b1, 14'd3, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, -1, 0, 32'h0};
        vt[1]  = '{1'b0, 14'd0, 1'b1, 32'hA0, 1'b1, 1'b1, 1'b0,  0, 0, 32'hA0};
        vt[2]  = '{1'b0, 14'd0, 1'b1, 32'hA1, 1'b1, 1'b1, 1'b0,  1, 0, 32'hA1};
        vt[3]  = '{1'b0, 14'd0, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b1,  2, 0, 32'hA2};
        vt[4]  = '{1'b0, 14'd0, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, -1, 0, 32'h0};
        vt[5]  = '{1'b1, 14'd2, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, -1, 0, 32'h0};
        vt[6]  = '{1'b0, 14'd0, 1'b1, 32'hB0, 1'b1, 1'b1, 1'b0,  0, 0, 32'hB0};
        vt[7]  = '{1'b0, 14'd0, 1'b0, 32'hB9, 1'b1, 1'b1, 1'b0, -1, 0, 32'h0};
        vt[8]  = '{1'b0, 14'd0, 1'b1, 32'hB1, 1'b0, 1'b0, 1'b1,  1, 0, 32'hB1};
        vt[9]  = '{1'b0, 14'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, -1, 0, 32'h0};
        vt[10] = '{1'b1, 14'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, -1, 0, 32'h0};
        vt[11] = '{1'b0, 14'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, -1, 0, 32'h0};
        vt[12] = '{1'b1, 14'd2, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, -1, 0, 32'h0};
        vt[13] = '{1'b1, 14'd5, 1'b1, 32'hC0, 1'b1, 1'b1, 1'b0,  0, 0, 32'hC0};
        vt[14] = '{1'b0, 14'd0, 1'b1, 32'hC1, 1'b0, 1'b0, 1'b1,  1, 0, 32'hC1};
        vt[15] = '{1'b1, 14'd3, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, -1, 0, 32'h0};
        vt[16] = '{1'b0, 14'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, -1, 0, 32'h0};

        // Reset state
        #12;
        chk("reset in_ready", in_ready, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset strobe", scan(), -1);
        chk("reset addr sum", addr_sum(), 0);
        chk("reset SRAM_D", sram_d, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle table
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            start    = vt[i].start;
            len      = vt[i].len;
            in_valid = vt[i].vld;
            in_data  = vt[i].dat;
            @(posedge clk); #1;
            chk($sformatf("row%0d in_ready", i), in_ready, vt[i].e_rdy);
            chk($sformatf("row%0d busy", i), busy, vt[i].e_busy);
            chk($sformatf("row%0d done", i), done, vt[i].e_done);
            chk($sformatf("row%0d strobe bank", i), scan(), vt[i].e_bank);
            if (vt[i].e_bank >= 0) begin
                chk($sformatf("row%0d addr", i), a_wr[vt[i].e_bank], vt[i].e_addr);
                chk($sformatf("row%0d data", i), sram_d, vt[i].e_dat);
            end
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;

        // 65 words: wrap from bank 63 to bank 0 at the next address
        run_stream(65, 32'h1000, 200);
        chk("len65 done seen", s_done, 1);
        chk("len65 strobes", s_cnt, 65);
        chk("len65 order", s_bad, 0);
        chk("len65 w63 bank", s_w63_b, 63);
        chk("len65 w63 addr", s_w63_a, 0);
        chk("len65 w64 bank", s_w64_b, 0);
        chk("len65 w64 addr", s_w64_a, 1);
        chk("len65 done with strobe", s_done_last, 1);
        chk("len65 bank63 addr hold", a_wr[63], 0);
        chk("len65 in_ready after", in_ready, 0);
        @(posedge clk); #1;
        chk("len65 done one cycle", done, 0);

        // Oversized length clamps to a full pass
        run_stream(9000, 32'h0002_0000, 9000);
        chk("len9000 done seen", s_done, 1);
        chk("len9000 strobes", s_cnt, 8192);
        chk("len9000 order", s_bad, 0);
        chk("len9000 last bank", s_lb, 63);
        chk("len9000 last addr", s_la, 127);
        chk("len9000 done with strobe", s_done_last, 1);
        @(posedge clk); #1;
        chk("len9000 no extra strobe", scan(), -1);
        chk("len9000 idle in_ready", in_ready, 0);

        // Asynchronous reset while a write strobe is live
        @(negedge clk);
        start = 1'b1; len = 14'd10;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 32'h55;
        @(posedge clk); #1;
        in_data = 32'h66;
        @(posedge clk); #2;
        chk("pre-reset strobe bank", scan(), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset strobe", scan(), -1);
        chk("midreset in_ready", in_ready, 0);
        chk("midreset busy", busy, 0);
        chk("midreset addr sum", addr_sum(), 0);
        chk("midreset SRAM_D", sram_d, 0);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset in_ready", in_ready, 0);

`ifdef SRAM_WR_ABORT_EN
        // Abort on the 5th accept: that word is still written, no done
        @(negedge clk);
        start = 1'b1; len = 14'd20;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1;
        n = 0; d = 0;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'h300 + i;
            abort = (i == 4);
            @(posedge clk); #1;
            if (scan() >= 0) n++;
            if (done) d++;
            @(negedge clk);
        end
        abort = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (scan() >= 0) n++;
            if (done) d++;
            @(negedge clk);
        end
        chk("abort strobes", n, 5);
        chk("abort no done", d, 0);
        chk("abort in_ready", in_ready, 0);
        chk("abort busy", busy, 0);
`else
        n = 0; d = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
